// File: rtl/svm_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// svm_pipe_ctrl
//
// Sequencer for the NUM_FEAT-stage systolic SVM kernel pipeline.
//
// A run is started by 'start' while idle. The controller then presents every
// (test instance, support vector) pair exactly once, in order, one pair per
// enabled cycle. It drives the indices and the accumulate first/last strobes.
// Each instance's final pair is tagged into a LAT-deep delay line that moves
// in lock-step with the pipeline. When the tag leaves the line, the pipeline
// output is captured. On the following cycle it is written to the result
// buffer.
//
// Handshake semantics: there is no ready/valid back-pressure on this block.
// 'stall' is a global freeze of the pipeline, the sequencer state and the
// delay line. 'issue' marks a pair that the pipeline consumes this cycle, so
// issue is never high while stalled. 'res_we' is a fire-and-forget strobe to
// a buffer that never stalls.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous reset, active-high
//   start      in   begin a run (only looked at while idle)
//   stall      in   freeze pipeline and controller this cycle
//   pipe_en    out  pipeline stage enable (= !stall)
//   issue      out  a valid pair is presented this cycle
//   sv_idx     out  support vector index of the presented pair
//   test_idx   out  test instance index of the presented pair
//   acc_first  out  issue of the first SV of an instance (load + clear)
//   acc_last   out  issue of the last SV of an instance
//   result_in  in   pipeline output
//   res_we     out  result buffer write strobe (one-cycle pulse)
//   res_addr   out  instance index of the written result
//   res_data   out  result written
//   busy       out  controller is not idle
//   done       out  one-cycle pulse, run complete
// ---------------------------------------------------------------------------
module svm_pipe_ctrl #(
   parameter int NUM_FEAT   = 2,
   parameter int NUM_SV     = 3,
   parameter int NUM_INST   = 2,
   parameter int ACCUM_SIZE = 64,
   // Index widths are kept at least one bit wide so that a single support
   // vector or a single instance still yields a legal port.
   localparam int SV_W = (NUM_SV   > 1) ? $clog2(NUM_SV)   : 1,
   localparam int TI_W = (NUM_INST > 1) ? $clog2(NUM_INST) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stall,
   output logic                  pipe_en,
   output logic                  issue,
   output logic [SV_W-1:0]       sv_idx,
   output logic [TI_W-1:0]       test_idx,
   output logic                  acc_first,
   output logic                  acc_last,
   input  logic [ACCUM_SIZE-1:0] result_in,
   output logic                  res_we,
   output logic [TI_W-1:0]       res_addr,
   output logic [ACCUM_SIZE-1:0] res_data,
   output logic                  busy,
   output logic                  done
);

   // Pipeline latency equals the number of feature stages.
   localparam int LAT = NUM_FEAT;

   localparam logic [SV_W-1:0] SV_LAST   = SV_W'(NUM_SV - 1);
   localparam logic [TI_W-1:0] INST_LAST = TI_W'(NUM_INST - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                state_q,    state_d;
   logic [SV_W-1:0]       sv_idx_q,   sv_idx_d;
   logic [TI_W-1:0]       test_idx_q, test_idx_d;

   // Delay line: one tag bit plus the instance index per stage.
   logic [LAT-1:0]           tag_q,  tag_d;
   logic [LAT-1:0][TI_W-1:0] inst_q, inst_d;

   logic                  res_we_q,   res_we_d;
   logic [TI_W-1:0]       res_addr_q, res_addr_d;
   logic [ACCUM_SIZE-1:0] res_data_q, res_data_d;

   logic                  issue_c;
   logic                  done_c;
   logic                  acc_last_c;
   logic                  tag_exit;

   // ------------------------------------------------------------------
   // Sequencer: next state, index counters, issue/done strobes
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      sv_idx_d   = sv_idx_q;
      test_idx_d = test_idx_q;
      issue_c    = 1'b0;
      done_c     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Stall has no effect here; a start is accepted regardless.
            if (start) begin
               state_d    = ST_ISSUE;
               sv_idx_d   = '0;
               test_idx_d = '0;
            end
         end

         ST_ISSUE: begin
            issue_c = !stall;
            if (!stall) begin
               if (sv_idx_q == SV_LAST) begin
                  sv_idx_d = '0;
                  if (test_idx_q == INST_LAST) begin
                     test_idx_d = '0;
                     state_d    = ST_DRAIN;
                  end else begin
                     test_idx_d = test_idx_q + TI_W'(1);
                  end
               end else begin
                  sv_idx_d = sv_idx_q + SV_W'(1);
               end
            end
         end

         ST_DRAIN: begin
            // The last tag is the newest entry, so an empty line means it has
            // exited and its write is on the output this cycle. Stall holds
            // the transition; the write itself still completes.
            if (!stall && (tag_q == '0)) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            done_c     = 1'b1;
            state_d    = ST_IDLE;
            sv_idx_d   = '0;
            test_idx_d = '0;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign acc_last_c = issue_c && (sv_idx_q == SV_LAST);

   // ------------------------------------------------------------------
   // Tag delay line: advances only with the pipeline
   // ------------------------------------------------------------------
   always_comb begin
      tag_d  = tag_q;
      inst_d = inst_q;
      if (!stall) begin
         tag_d[0]  = acc_last_c;
         inst_d[0] = test_idx_q;
         for (int i = 1; i < LAT; i++) begin
            tag_d[i]  = tag_q[i-1];
            inst_d[i] = inst_q[i-1];
         end
      end
   end

   // A tag in the last stage leaves on the next enabled edge, which is the
   // same edge on which the pipeline result for that instance is valid.
   assign tag_exit = tag_q[LAT-1] && !stall;

   // ------------------------------------------------------------------
   // Result capture: sampled on exit, presented one cycle later
   // ------------------------------------------------------------------
   always_comb begin
      res_we_d   = tag_exit;
      res_addr_d = res_addr_q;
      res_data_d = res_data_q;
      if (tag_exit) begin
         res_addr_d = inst_q[LAT-1];
         res_data_d = result_in;
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sv_idx_q   <= '0;
         test_idx_q <= '0;
         tag_q      <= '0;
         inst_q     <= '0;
         res_we_q   <= 1'b0;
         res_addr_q <= '0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         sv_idx_q   <= sv_idx_d;
         test_idx_q <= test_idx_d;
         tag_q      <= tag_d;
         inst_q     <= inst_d;
         res_we_q   <= res_we_d;
         res_addr_q <= res_addr_d;
         res_data_q <= res_data_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign pipe_en   = !stall;
   assign issue     = issue_c;
   assign sv_idx    = sv_idx_q;
   assign test_idx  = test_idx_q;
   assign acc_first = issue_c && (sv_idx_q == '0);
   assign acc_last  = acc_last_c;
   assign res_we    = res_we_q;
   assign res_addr  = res_addr_q;
   assign res_data  = res_data_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_c;

endmodule

// File: tb/tb_svm_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_svm_pipe_ctrl
//
// Two instances run side by side on shared inputs:
//   dut_a : defaults (NUM_FEAT=2, NUM_SV=3, NUM_INST=2)
//   dut_b : NUM_FEAT=3, NUM_SV=1, NUM_INST=4
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_svm_pipe_ctrl;

   localparam int MAXC = 128;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start;
   logic        stall;
   logic [63:0] result_in;

   logic        pipe_en_a, issue_a, acc_first_a, acc_last_a, res_we_a, busy_a, done_a;
   logic [1:0]  sv_idx_a;
   logic [0:0]  test_idx_a, res_addr_a;
   logic [63:0] res_data_a;

   logic        pipe_en_b, issue_b, acc_first_b, acc_last_b, res_we_b, busy_b, done_b;
   logic [0:0]  sv_idx_b;
   logic [1:0]  test_idx_b, res_addr_b;
   logic [63:0] res_data_b;

   svm_pipe_ctrl dut_a (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .pipe_en(pipe_en_a), .issue(issue_a), .sv_idx(sv_idx_a), .test_idx(test_idx_a),
      .acc_first(acc_first_a), .acc_last(acc_last_a), .result_in(result_in),
      .res_we(res_we_a), .res_addr(res_addr_a), .res_data(res_data_a),
      .busy(busy_a), .done(done_a)
   );

   svm_pipe_ctrl #(.NUM_FEAT(3), .NUM_SV(1), .NUM_INST(4), .ACCUM_SIZE(64)) dut_b (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .pipe_en(pipe_en_b), .issue(issue_b), .sv_idx(sv_idx_b), .test_idx(test_idx_b),
      .acc_first(acc_first_b), .acc_last(acc_last_b), .result_in(result_in),
      .res_we(res_we_b), .res_addr(res_addr_b), .res_data(res_data_b),
      .busy(busy_b), .done(done_b)
   );

   // ---------------- scoreboard counters ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int cyc, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int   cyc;
      logic stall;
      logic issue;
      int   sv;
      int   ti;
      logic af;
      logic al;
      logic we;
      int   addr;
      int   data;
      logic done;
      logic busy;
      logic issue_b;
      logic we_b;
      int   addr_b;
      logic done_b;
   } vec_t;

   vec_t tab[32];
   int   n_rows = 0;

   task automatic add_row(input int c, input logic st, input logic is, input int sv,
                          input int ti, input logic af, input logic al, input logic we,
                          input int ad, input int da, input logic dn, input logic bz,
                          input logic ib, input logic wb, input int ab, input logic db);
      tab[n_rows] = '{c, st, is, sv, ti, af, al, we, ad, da, dn, bz, ib, wb, ab, db};
      n_rows++;
   endtask

   // Starts a run with result_in = run-relative cycle number and checks rows.
   task automatic run_table(input int lo, input int hi);
      start = 1'b1;
      stall = 1'b0;
      result_in = '0;
      tick();
      start = 1'b0;
      for (int r = lo; r <= hi; r++) begin
         stall     = tab[r].stall;
         result_in = 64'(tab[r].cyc);
         @(negedge clk);
         chk("pipe_en",   tab[r].cyc, pipe_en_a,   !tab[r].stall);
         chk("issue",     tab[r].cyc, issue_a,     tab[r].issue);
         chk("sv_idx",    tab[r].cyc, sv_idx_a,    tab[r].sv);
         chk("test_idx",  tab[r].cyc, test_idx_a,  tab[r].ti);
         chk("acc_first", tab[r].cyc, acc_first_a, tab[r].af);
         chk("acc_last",  tab[r].cyc, acc_last_a,  tab[r].al);
         chk("res_we",    tab[r].cyc, res_we_a,    tab[r].we);
         chk("res_addr",  tab[r].cyc, res_addr_a,  tab[r].addr);
         chk("res_data",  tab[r].cyc, res_data_a,  tab[r].data);
         chk("done",      tab[r].cyc, done_a,      tab[r].done);
         chk("busy",      tab[r].cyc, busy_a,      tab[r].busy);
         chk("b_issue",   tab[r].cyc, issue_b,     tab[r].issue_b);
         chk("b_first",   tab[r].cyc, acc_first_b, tab[r].issue_b);
         chk("b_last",    tab[r].cyc, acc_last_b,  tab[r].issue_b);
         chk("b_res_we",  tab[r].cyc, res_we_b,    tab[r].we_b);
         chk("b_done",    tab[r].cyc, done_b,      tab[r].done_b);
         if (tab[r].we_b) begin
            chk("b_res_addr", tab[r].cyc, res_addr_b, tab[r].addr_b);
            chk("b_res_data", tab[r].cyc, res_data_b, 64'(tab[r].cyc - 1));
         end
         tick();
      end
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct packed {
      logic        pipe_en;
      logic        issue;
      logic [3:0]  sv;
      logic [3:0]  ti;
      logic        af;
      logic        al;
      logic        we;
      logic [3:0]  addr;
      logic [63:0] data;
      logic        busy;
      logic        done;
   } obs_t;

   logic        stall_arr [MAXC];
   logic [63:0] res_arr   [MAXC];
   obs_t        exp_tab   [2][MAXC];
   int          done_at   [2];
   logic [3:0]  hold_addr [2];
   logic [63:0] hold_data [2];

   // Pair p is presented on the p-th unstalled cycle. An instance's result is
   // taken LAT unstalled cycles after its last pair and written on the next
   // cycle; done follows the first unstalled cycle at or after the last write.
   task automatic build_model(input int d, input int nsv, input int ninst, input int lat);
      logic        wr_f [MAXC];
      logic [3:0]  wr_a [MAXC];
      logic [63:0] wr_d [MAXC];
      int          total, p, pb, s, cnt, w, dc;
      logic [3:0]  ha;
      logic [63:0] hd;
      obs_t        o;
      for (int i = 0; i < MAXC; i++) begin
         wr_f[i] = 1'b0;
         wr_a[i] = '0;
         wr_d[i] = '0;
      end
      total = nsv * ninst;
      p = 0;
      w = 0;
      for (int t = 0; t < MAXC - 3 && p < total; t++) begin
         if (!stall_arr[t]) begin
            if (p % nsv == nsv - 1) begin
               s = t;
               cnt = 0;
               while (cnt < lat && s < MAXC - 3) begin
                  s++;
                  if (!stall_arr[s]) cnt++;
               end
               wr_f[s+1] = 1'b1;
               wr_a[s+1] = 4'(p / nsv);
               wr_d[s+1] = res_arr[s];
               w = s + 1;
            end
            p++;
         end
      end
      dc = w;
      while (dc < MAXC - 2 && stall_arr[dc]) dc++;
      done_at[d] = dc + 1;
      ha = hold_addr[d];
      hd = hold_data[d];
      pb = 0;
      for (int t = 0; t < MAXC; t++) begin
         o.pipe_en = !stall_arr[t];
         o.issue   = !stall_arr[t] && (pb < total);
         o.sv      = (pb < total) ? 4'(pb % nsv) : 4'd0;
         o.ti      = (pb < total) ? 4'(pb / nsv) : 4'd0;
         o.af      = o.issue && (o.sv == 4'd0);
         o.al      = o.issue && (int'(o.sv) == nsv - 1);
         if (wr_f[t]) begin
            ha = wr_a[t];
            hd = wr_d[t];
         end
         o.we      = wr_f[t];
         o.addr    = ha;
         o.data    = hd;
         o.busy    = (t <= done_at[d]);
         o.done    = (t == done_at[d]);
         if (o.issue) pb++;
         exp_tab[d][t] = o;
      end
      hold_addr[d] = ha;
      hold_data[d] = hd;
   endtask

   function automatic obs_t get_obs_a();
      obs_t o;
      o.pipe_en = pipe_en_a;   o.issue = issue_a;
      o.sv      = 4'(sv_idx_a); o.ti   = 4'(test_idx_a);
      o.af      = acc_first_a; o.al    = acc_last_a;
      o.we      = res_we_a;    o.addr  = 4'(res_addr_a);
      o.data    = res_data_a;  o.busy  = busy_a;
      o.done    = done_a;
      return o;
   endfunction

   function automatic obs_t get_obs_b();
      obs_t o;
      o.pipe_en = pipe_en_b;   o.issue = issue_b;
      o.sv      = 4'(sv_idx_b); o.ti   = 4'(test_idx_b);
      o.af      = acc_first_b; o.al    = acc_last_b;
      o.we      = res_we_b;    o.addr  = 4'(res_addr_b);
      o.data    = res_data_b;  o.busy  = busy_b;
      o.done    = done_b;
      return o;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int len;
      int pct;

      // cyc st | is sv ti af al | we ad da | dn bz | ib wb ab db
      // Run with no stall, result_in = cycle number.
      add_row( 0,0, 1,0,0,1,0, 0,0,0, 0,1, 1,0,0,0);
      add_row( 1,0, 1,1,0,0,0, 0,0,0, 0,1, 1,0,0,0);
      add_row( 2,0, 1,2,0,0,1, 0,0,0, 0,1, 1,0,0,0);
      add_row( 3,0, 1,0,1,1,0, 0,0,0, 0,1, 1,0,0,0);
      add_row( 4,0, 1,1,1,0,0, 0,0,0, 0,1, 0,1,0,0);
      add_row( 5,0, 1,2,1,0,1, 1,0,4, 0,1, 0,1,1,0);
      add_row( 6,0, 0,0,0,0,0, 0,0,4, 0,1, 0,1,2,0);
      add_row( 7,0, 0,0,0,0,0, 0,0,4, 0,1, 0,1,3,0);
      add_row( 8,0, 0,0,0,0,0, 1,1,7, 0,1, 0,0,0,1);
      add_row( 9,0, 0,0,0,0,0, 0,1,7, 1,1, 0,0,0,0);
      add_row(10,0, 0,0,0,0,0, 0,1,7, 0,0, 0,0,0,0);
      // Same run with stall at cycles 1-2; everything slips by two.
      add_row( 0,0, 1,0,0,1,0, 0,1,7, 0,1, 1,0,0,0);
      add_row( 1,1, 0,1,0,0,0, 0,1,7, 0,1, 0,0,0,0);
      add_row( 2,1, 0,1,0,0,0, 0,1,7, 0,1, 0,0,0,0);
      add_row( 3,0, 1,1,0,0,0, 0,1,7, 0,1, 1,0,0,0);
      add_row( 4,0, 1,2,0,0,1, 0,1,7, 0,1, 1,0,0,0);
      add_row( 5,0, 1,0,1,1,0, 0,1,7, 0,1, 1,0,0,0);
      add_row( 6,0, 1,1,1,0,0, 0,1,7, 0,1, 0,1,0,0);
      add_row( 7,0, 1,2,1,0,1, 1,0,6, 0,1, 0,1,1,0);
      add_row( 8,0, 0,0,0,0,0, 0,0,6, 0,1, 0,1,2,0);
      add_row( 9,0, 0,0,0,0,0, 0,0,6, 0,1, 0,1,3,0);
      add_row(10,0, 0,0,0,0,0, 1,1,9, 0,1, 0,0,0,1);
      add_row(11,0, 0,0,0,0,0, 0,1,9, 1,1, 0,0,0,0);
      add_row(12,0, 0,0,0,0,0, 0,1,9, 0,0, 0,0,0,0);

      // ---- reset state ----
      rst = 1'b1;
      start = 1'b0;
      stall = 1'b1;
      result_in = '0;
      @(negedge clk);
      chk("rst_pipe_en", 0, pipe_en_a, 1'b0);
      chk("rst_issue",   0, issue_a,   1'b0);
      chk("rst_busy",    0, busy_a,    1'b0);
      chk("rst_sv_idx",  0, sv_idx_a,  '0);
      chk("rst_res_we",  0, res_we_a,  1'b0);
      chk("rst_data",    0, res_data_a, '0);
      chk("rst_done",    0, done_a,    1'b0);
      stall = 1'b0;
      #1;
      chk("rst_pipe_en_hi", 0, pipe_en_a, 1'b1);
      tick();
      rst = 1'b0;
      tick();

      // ---- directed tables: plain run, then stalled run ----
      run_table(0, 10);
      run_table(11, n_rows - 1);

      // ---- start held high: no restart until idle is re-entered ----
      start = 1'b1;
      stall = 1'b0;
      tick();
      for (int t = 0; t <= 21; t++) begin
         start = (t <= 10);
         result_in = 64'(t);
         @(negedge clk);
         case (t)
            6:  begin chk("hold_busy", t, busy_a, 1'b1); chk("hold_issue", t, issue_a, 1'b0); end
            8:  chk("hold_we", t, res_we_a, 1'b1);
            9:  chk("hold_done", t, done_a, 1'b1);
            10: begin chk("hold_idle", t, busy_a, 1'b0); chk("hold_noissue", t, issue_a, 1'b0); end
            11: begin chk("restart_issue", t, issue_a, 1'b1); chk("restart_first", t, acc_first_a, 1'b1); end
            20: chk("restart_done", t, done_a, 1'b1);
            21: chk("restart_idle", t, busy_a, 1'b0);
            default: ;
         endcase
         tick();
      end

      // ---- start pulsed during done only: ignored ----
      start = 1'b1;
      tick();
      for (int t = 0; t <= 11; t++) begin
         start = (t == 9);
         result_in = 64'(t);
         @(negedge clk);
         case (t)
            9:  chk("pulse_done", t, done_a, 1'b1);
            10: chk("pulse_idle10", t, busy_a, 1'b0);
            11: begin chk("pulse_idle11", t, busy_a, 1'b0); chk("pulse_noissue", t, issue_a, 1'b0); end
            default: ;
         endcase
         tick();
      end

      // ---- reset mid-run at cycle 4 ----
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 0; t < 4; t++) begin
         result_in = 64'(t);
         tick();
      end
      rst = 1'b1;
      #1;
      chk("mid_rst_issue",  4, issue_a,     1'b0);
      chk("mid_rst_busy",   4, busy_a,      1'b0);
      chk("mid_rst_sv",     4, sv_idx_a,    '0);
      chk("mid_rst_ti",     4, test_idx_a,  '0);
      chk("mid_rst_first",  4, acc_first_a, 1'b0);
      chk("mid_rst_we",     4, res_we_a,    1'b0);
      chk("mid_rst_addr",   4, res_addr_a,  '0);
      chk("mid_rst_data",   4, res_data_a,  '0);
      chk("mid_rst_done",   4, done_a,      1'b0);
      chk("mid_rst_b_busy", 4, busy_b,      1'b0);
      tick();
      rst = 1'b0;
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         chk("post_rst_we",   t, res_we_a, 1'b0);
         chk("post_rst_done", t, done_a,   1'b0);
         chk("post_rst_busy", t, busy_a,   1'b0);
         tick();
      end
      run_table(0, 10);

      // ---- randomized runs against the reference model ----
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         hold_addr[d] = '0;
         hold_data[d] = '0;
      end
      for (int run = 0; run < 10; run++) begin
         pct = $urandom_range(0, 40);
         for (int i = 0; i < MAXC; i++) begin
            stall_arr[i] = ($urandom_range(0, 99) < pct);
            res_arr[i]   = {$urandom, $urandom};
         end
         build_model(0, 3, 2, 2);
         build_model(1, 1, 4, 3);
         len = (done_at[0] > done_at[1]) ? done_at[0] + 2 : done_at[1] + 2;
         if (len > MAXC - 1) len = MAXC - 1;
         start = 1'b1;
         stall = 1'($urandom_range(0, 1));
         result_in = {$urandom, $urandom};
         tick();
         start = 1'b0;
         for (int t = 0; t <= len; t++) begin
            stall = stall_arr[t];
            result_in = res_arr[t];
            @(negedge clk);
            chk("rand_a", t, get_obs_a(), exp_tab[0][t]);
            chk("rand_b", t, get_obs_b(), exp_tab[1][t]);
            tick();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
